// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters/UART transmitter (master) and the
// round-robin arbiter (slave).
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        transmitting;
  logic        transmitted;
  logic        err;

  modport master (
    output req, req_data, transmitting, transmitted,
    input  grant, ack, done, tx_start, tx_data, err
  );

  modport slave (
    input  req, req_data, transmitting, transmitted,
    output grant, ack, done, tx_start, tx_data, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter in front of a single UART transmitter.
// Define UART_ARB_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog that pulses err.
module uart_tx_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StWaitBusy = 2'b01,
    StWaitDone = 2'b10
  } state_e;

  state_e      state_q;
  logic [3:0]  grant_q;
  logic [3:0]  ack_q;
  logic [3:0]  done_q;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;
  logic [1:0]  last_ptr_q;
  logic [1:0]  owner_q;

  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic        win_valid;
  logic        in_wait;
  logic        timeout_hit;

  assign in_wait = (state_q == StWaitBusy) || (state_q == StWaitDone);

  // Search upward from the requester after the last owner, wrapping at 3.
  always_comb begin
    win_idx   = 2'd0;
    win_valid = 1'b0;
    cand      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_ptr_q + 2'(i);
      if (!win_valid && bus.req[cand]) begin
        win_idx   = cand;
        win_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= 4'b0000;
      ack_q      <= 4'b0000;
      done_q     <= 4'b0000;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      last_ptr_q <= 2'd3;
      owner_q    <= 2'd0;
    end else begin
      ack_q      <= 4'b0000;
      done_q     <= 4'b0000;
      tx_start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (win_valid) begin
            tx_data_q  <= bus.req_data[{win_idx, 3'b000} +: 8];
            grant_q    <= 4'b0001 << win_idx;
            ack_q      <= 4'b0001 << win_idx;
            tx_start_q <= 1'b1;
            owner_q    <= win_idx;
            state_q    <= StWaitBusy;
          end
        end
        StWaitBusy, StWaitDone: begin
          // Completion takes precedence over both the busy hop and the watchdog.
          if (bus.transmitted) begin
            done_q     <= grant_q;
            grant_q    <= 4'b0000;
            last_ptr_q <= owner_q;
            state_q    <= StIdle;
          end else if (timeout_hit) begin
            grant_q    <= 4'b0000;
            last_ptr_q <= owner_q;
            state_q    <= StIdle;
          end else if (state_q == StWaitBusy && bus.transmitting) begin
            state_q <= StWaitDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        err_q;

  assign timeout_hit = in_wait && !bus.transmitted && ((cnt_q + 16'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (state_q == StIdle && win_valid) begin
        cnt_q <= 16'd0;
      end else if (in_wait) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign bus.err = err_q;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^{TIMEOUT_CYCLES, in_wait};
  assign bus.err        = 1'b0;
`endif

  assign bus.grant    = grant_q;
  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

endmodule
